mult_lut: RTL and testbench



---
 rtl/mult_lut_pkg.sv | 19 +
 rtl/mult_lut_if.sv | 23 ++
 rtl/mult_lut_ram.sv | 26 ++
 rtl/mult_lut.sv | 139 +++++++++++++
 tb/tb_mult_lut.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_lut_pkg.sv
// Shared types and sizing helpers for the lookup-table multiplier.
package mult_lut_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Number of table entries for a given operand width.
    function automatic int depth(input int width);
        return 1 << (2 * width);
    endfunction

    // Table index of the product a*b: a in the upper half, b in the lower half.
    function automatic int addr(input int width, input int a, input int b);
        return (a << width) | b;
    endfunction

endpackage

// File: rtl/mult_lut_if.sv
// Request/response bundle of mult_lut; master drives requests, slave answers.
interface mult_lut_if #(
    parameter int WIDTH = 3
);
    logic                 init;
    logic                 read;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   result;
    logic                 valid;
    logic                 busy;
    logic                 err;

    modport master (
        output init, read, a, b,
        input  result, valid, busy, err
    );

    modport slave (
        input  init, read, a, b,
        output result, valid, busy, err
    );
endinterface

// File: rtl/mult_lut_ram.sv
// Simple dual-port RAM: one synchronous write port, one enabled synchronous read port.
module mult_lut_ram #(
    parameter int AW = 6,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/mult_lut.sv
// Lookup-table multiplier that fills its own RAM by repeated addition, then serves reads.
// Optional self-check against a '*' product is built when MULT_LUT_CHECK_EN is defined.
module mult_lut
    import mult_lut_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    mult_lut_if.slave bus
);

    localparam int AW = 2 * WIDTH;
    localparam int DW = 2 * WIDTH;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic [DW-1:0]    acc;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             fill_last;
    logic             wr_en;
    logic             rd_en;
    logic [DW-1:0]    rd_q;
    logic             vld_p1;
    logic             have_data;

    assign wr_addr   = AW'(addr(WIDTH, int'(fa), int'(fb)));
    assign rd_addr   = AW'(addr(WIDTH, int'(bus.a), int'(bus.b)));
    assign fill_last = (state == S_FILL) && (wr_addr == AW'(depth(WIDTH) - 1));
    // init takes priority over both the current fill write and any read
    assign wr_en     = (state == S_FILL) && !bus.init;
    assign rd_en     = (state == S_READY) && bus.read && !bus.init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FILL: begin
                if (bus.init) begin
                    state_nx = S_FILL;
                end else if (fill_last) begin
                    state_nx = S_READY;
                end
            end
            S_READY: begin
                if (bus.init) begin
                    state_nx = S_FILL;
                end
            end
            default: state_nx = S_FILL;
        endcase
    end

    // Fill engine: acc tracks fa*fb by adding fa on each fb step; both counters wrap to 0 after the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa  <= '0;
            fb  <= '0;
            acc <= '0;
        end else if (bus.init) begin
            fa  <= '0;
            fb  <= '0;
            acc <= '0;
        end else if (wr_en) begin
            fb <= fb + 1'b1;
            if (fb == '1) begin
                fa  <= fa + 1'b1;
                acc <= '0;
            end else begin
                acc <= acc + DW'(fa);
            end
        end
    end

    mult_lut_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .wa  (wr_addr),
        .wd  (acc),
        .re  (rd_en),
        .ra  (rd_addr),
        .rd  (rd_q)
    );

    // ---- stage p1: RAM output and its valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            have_data <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                have_data <= 1'b1;
            end
        end
    end

    // The RAM read register holds between reads; masking it until the first read gives a zero reset value.
    assign bus.result = have_data ? rd_q : '0;
    assign bus.valid  = vld_p1;
    assign bus.busy   = (state == S_FILL);

`ifdef MULT_LUT_CHECK_EN
    logic [DW-1:0] chk_p1;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            chk_p1 <= DW'(bus.a) * DW'(bus.b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (vld_p1 && (rd_q != chk_p1)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_lut.sv
// Scoreboard bench for mult_lut: a WIDTH=3 and a WIDTH=4 instance on a shared clock.
module tb_mult_lut;
    import mult_lut_pkg::*;

    logic clk;
    logic rst3_n;
    logic rst4_n;

    mult_lut_if #(.WIDTH(3)) if3 ();
    mult_lut_if #(.WIDTH(4)) if4 ();

    mult_lut #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(if3));
    mult_lut #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst4_n), .bus(if4));

    int n_checks = 0;
    int n_fail   = 0;
    int q3[$];
    int q4[$];
    int e3;
    int e4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set3(input logic i, input logic r, input int a, input int b);
        if3.init = i;
        if3.read = r;
        if3.a    = 3'(a);
        if3.b    = 3'(b);
    endtask

    task automatic set4(input logic i, input logic r, input int a, input int b);
        if4.init = i;
        if4.read = r;
        if4.a    = 4'(a);
        if4.b    = 4'(b);
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 3) ? if3.busy : if4.busy;
    endfunction

    function automatic int result_of(input int sel);
        return (sel == 3) ? int'(if3.result) : int'(if4.result);
    endfunction

    // Counts sample points with busy high, starting at the sample right after the fill began.
    task automatic count_busy(input int sel, output int n, output logic res_nz);
        n      = 0;
        res_nz = 1'b0;
        while ((busy_of(sel) === 1'b1) && (n < 2000)) begin
            n++;
            if (result_of(sel) != 0) res_nz = 1'b1;
            step();
        end
    endtask

    always @(negedge clk) begin
        if (if3.valid === 1'b1) begin
            if (q3.size() == 0) begin
                check_eq("w3_unexpected_valid", 32'(if3.valid), 32'd0);
            end else begin
                e3 = q3.pop_front();
                check_eq("w3_result", 32'(if3.result), 32'(e3));
            end
        end
    end

    always @(negedge clk) begin
        if (if4.valid === 1'b1) begin
            if (q4.size() == 0) begin
                check_eq("w4_unexpected_valid", 32'(if4.valid), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check_eq("w4_result", 32'(if4.result), 32'(e4));
            end
        end
    end

    initial begin
        int   n;
        logic nz;
        rst3_n = 1'b1;
        rst4_n = 1'b1;
        set3(0, 0, 0, 0);
        set4(0, 0, 0, 0);
        #2;
        rst3_n = 1'b0;
        rst4_n = 1'b0;
        repeat (3) step();

        check_eq("w3_rst_result", 32'(if3.result), 32'd0);
        check_eq("w3_rst_valid",  32'(if3.valid),  32'd0);
        check_eq("w3_rst_busy",   32'(if3.busy),   32'd1);
        check_eq("w3_rst_err",    32'(if3.err),    32'd0);
        check_eq("w4_rst_busy",   32'(if4.busy),   32'd1);

        // Reset-release fill
        rst3_n = 1'b1;
        count_busy(3, n, nz);
        check_eq("w3_fill_cycles", 32'(n), 32'd64);
        check_eq("w3_fill_result_zero", 32'(nz), 32'd0);
        check_eq("w3_result_after_fill", 32'(if3.result), 32'd0);

        // Single read and hold
        set3(0, 1, 7, 7);
        q3.push_back(49);
        step();
        check_eq("w3_valid_7x7", 32'(if3.valid), 32'd1);
        set3(0, 0, 0, 0);
        step();
        check_eq("w3_valid_drop", 32'(if3.valid), 32'd0);
        check_eq("w3_result_hold", 32'(if3.result), 32'd49);

        // Back-to-back reads
        set3(0, 1, 3, 5); q3.push_back(15); step();
        check_eq("w3_b2b_valid0", 32'(if3.valid), 32'd1);
        set3(0, 1, 0, 6); q3.push_back(0);  step();
        check_eq("w3_b2b_valid1", 32'(if3.valid), 32'd1);
        set3(0, 1, 7, 1); q3.push_back(7);  step();
        check_eq("w3_b2b_valid2", 32'(if3.valid), 32'd1);
        set3(0, 0, 0, 0);
        step();
        check_eq("w3_b2b_valid_end", 32'(if3.valid), 32'd0);

        // init together with read: read dropped, fill restarts
        set3(1, 1, 1, 1);
        step();
        set3(0, 0, 0, 0);
        count_busy(3, n, nz);
        check_eq("w3_init_fill_cycles", 32'(n), 32'd64);
        set3(0, 1, 6, 4); q3.push_back(24); step();
        set3(0, 0, 0, 0); step();
        check_eq("w3_result_6x4", 32'(if3.result), 32'd24);

`ifdef MULT_LUT_CHECK_EN
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                set3(0, 1, a, b);
                q3.push_back(a * b);
                step();
            end
        end
        set3(0, 0, 0, 0);
        step();
        check_eq("w3_err_exhaustive", 32'(if3.err), 32'd0);
        u3.u_ram.mem[addr(3, 2, 3)] = 6'd7;
        set3(0, 1, 2, 3); q3.push_back(7); step();
        set3(0, 0, 0, 0); step();
        check_eq("w3_err_set", 32'(if3.err), 32'd1);
        set3(1, 0, 0, 0); step();
        set3(0, 0, 0, 0);
        count_busy(3, n, nz);
        check_eq("w3_err_sticky", 32'(if3.err), 32'd1);
`endif

        // WIDTH=4: reset at fill cycle 100, then full fill from release
        rst4_n = 1'b1;
        repeat (100) step();
        check_eq("w4_busy_midfill", 32'(if4.busy), 32'd1);
        rst4_n = 1'b0;
        #1;
        check_eq("w4_rst_mid_busy",   32'(if4.busy),   32'd1);
        check_eq("w4_rst_mid_valid",  32'(if4.valid),  32'd0);
        check_eq("w4_rst_mid_result", 32'(if4.result), 32'd0);
        step();
        step();
        rst4_n = 1'b1;
        count_busy(4, n, nz);
        check_eq("w4_fill_cycles", 32'(n), 32'd256);
        set4(0, 1, 15, 15); q4.push_back(225); step();
        set4(0, 1, 9, 13);  q4.push_back(117); step();
        set4(0, 0, 0, 0);   step();
        check_eq("w4_result_last", 32'(if4.result), 32'd117);

        step();
        step();
        check_eq("w3_sb_drain", 32'(q3.size()), 32'd0);
        check_eq("w4_sb_drain", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
